perceptron_introduction: RTL and testbench
==========================================

Name: perceptron_introduction

Overview:
- Single-layer perceptron with a step activation and the online perceptron learning rule.
- Computes the weighted sum of `input_units` signed fixed-point inputs plus a bias, registers a binary prediction, and updates weights and bias while `training` is high.
- Sits under board-level wrappers that stream labelled samples (e.g. logic AND) during training, then drive the inputs from switches for inference.

Parameters:
- input_units, 2, number of inputs and weights (>=1).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- values  in  sfp[input_units]  input sample, signed fixed point.
- training  in  1  1 = apply the learning rule this cycle; 0 = weights frozen.
- learning_rate  in  sfp  learning-rate step (ONE = 1.0).
- expected  in  sfp  target label for `values`: 0 or ONE.
- prediction  out  sfp  registered activation: ONE or 0.
- weights  out  sfp[input_units]  current weights, exposed for visibility.
- bias  out  sfp  current bias.

Behaviour:
- Number format (sfp): signed 32-bit Q16.16.
  - ONE = 32'h0001_0000.
  - Add/sub wrap at 32 bits.
  - mul(a,b) = 64-bit signed product arithmetically shifted right by 16, truncated to 32 bits.
- Reset (rst=0, asynchronous): all weights = 0, bias = 0, prediction = 0.
- Combinational, every cycle:
  - sum = bias + Σ mul(weights[i], values[i]).
  - act = (sum > 0) ? ONE : 0.
  - The comparison is strictly greater than zero, so sum = 0 gives act = 0.
- Registered, every posedge when not in reset: prediction <= act. Latency from `values` to `prediction` is 1 cycle.
- Training, on the same edge when training=1:
  - err = expected − act, using the combinational act of the current sample, not the registered prediction.
  - delta = mul(learning_rate, err).
  - weights[i] <= weights[i] + mul(delta, values[i]).
  - bias <= bias + delta.
  - err = 0 leaves all state unchanged.
- When training=0: weights and bias hold; prediction keeps tracking `values`.
- Each cycle is one independent sample. There is no handshake and no epoch counting inside the block.
- Reset asserted mid-training clears all learned state immediately. Learning resumes from zero on the first edge after release.
- `expected` values other than 0/ONE are processed arithmetically as given, with no clamping.

Decomposition:
- Package fixed_point_pkg, shared across the codebase:
  - typedef sfp (logic signed [31:0]).
  - FRAC_BITS = 16, ONE.
  - Functions int_to_sfp(int) (value << 16) and sfp_mul(a,b).
- Optional sub-module perceptron_dot: a combinational bias-plus-dot-product adder tree, parameterised by input_units.

Test Plan:
- Reset: rst=0 with arbitrary inputs -> weights = 0, bias = 0, prediction = 0; these hold while rst stays low.
- Single update: training=1, lr=ONE, values=(ONE,ONE), expected=ONE from reset -> after 1 edge weights = (ONE,ONE), bias = ONE, prediction = 0 (act was 0).
- AND training: lr=ONE, sample order (0,0)/0, (0,ONE)/0, (ONE,0)/0, (ONE,ONE)/ONE, one sample per cycle for 10 epochs.
  - Converges after epoch 5 to weights = (2·ONE, 1·ONE), bias = −2·ONE.
  - Epochs 6–10 produce no further change.
- Inference after AND training, training=0: (0,0)->0, (0,ONE)->0, (ONE,0)->0, (ONE,ONE)->ONE, each one cycle after the input is applied; weights unchanged.
- Frozen learning: training=0 with a mismatching expected -> weights and bias unchanged across 10 cycles.
- Async reset mid-training (assert between clock edges during epoch 3) -> outputs clear without waiting for an edge; retraining from zero reproduces the same converged values.

Source files
------------

// File: rtl/fixed_point_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fixed_point_pkg
// Purpose  : Shared signed Q16.16 fixed-point type, constants and helpers.
//            sfp add/sub are plain 32-bit wrapping arithmetic; sfp_mul keeps
//            the full 64-bit product and drops the 16 extra fraction bits.
// Contents : sfp        - signed 32-bit Q16.16 value
//            FRAC_BITS  - number of fraction bits (16)
//            ONE        - 1.0 in sfp
//            int_to_sfp - integer to sfp (value << 16)
//            sfp_mul    - fixed-point multiply
// Revision : 1.0 - initial release
// ============================================================================
package fixed_point_pkg;

  typedef logic signed [31:0] sfp;

  localparam int FRAC_BITS = 16;
  localparam sfp ONE       = 32'sh0001_0000;

  // Integer to Q16.16; upper integer bits that do not fit simply wrap.
  function automatic sfp int_to_sfp(input int value);
    return sfp'(value <<< FRAC_BITS);
  endfunction

  // Full-precision signed product, arithmetic shift back to Q16.16, then
  // truncation to 32 bits (overflow wraps, fraction rounds toward -inf).
  function automatic sfp sfp_mul(input sfp a, input sfp b);
    logic signed [63:0] a_ext;
    logic signed [63:0] b_ext;
    logic signed [63:0] product;
    a_ext   = {{32{a[31]}}, a};
    b_ext   = {{32{b[31]}}, b};
    product = a_ext * b_ext;
    return sfp'(product >>> FRAC_BITS);
  endfunction

endpackage : fixed_point_pkg
`default_nettype wire

// File: rtl/perceptron_dot.sv
`default_nettype none
// ============================================================================
// Module   : perceptron_dot
// Purpose  : Combinational bias-plus-dot-product for the perceptron:
//            sum = bias + sum_i sfp_mul(weights[i], values[i]).
//            All additions wrap at 32 bits.
// Params   : input_units - number of weight/value pairs (>= 1)
// Ports    : weights [input_units] in  sfp  current weights
//            values  [input_units] in  sfp  current input sample
//            bias                  in  sfp  current bias
//            sum                   out sfp  weighted sum including bias
// Revision : 1.0 - initial release
// ============================================================================
module perceptron_dot
  import fixed_point_pkg::*;
#(
  parameter int input_units = 2
) (
  input  sfp weights [input_units],
  input  sfp values  [input_units],
  input  sfp bias,
  output sfp sum
);

  sfp products [input_units];

  // One multiplier per input; all products are formed in parallel.
  generate
    for (genvar i = 0; i < input_units; i++) begin : g_product
      assign products[i] = sfp_mul(weights[i], values[i]);
    end
  endgenerate

  // Because sfp addition wraps modulo 2^32, the order of accumulation does
  // not change the result, so a simple chain is equivalent to any tree
  // arrangement the synthesis tool chooses to build.
  always_comb begin
    sfp acc;
    acc = bias;
    for (int i = 0; i < input_units; i++) begin
      acc = acc + products[i];
    end
    sum = acc;
  end

endmodule : perceptron_dot
`default_nettype wire

// File: rtl/perceptron_introduction.sv
`default_nettype none
// ============================================================================
// Module   : perceptron_introduction
// Purpose  : Single-layer perceptron with step activation and the online
//            perceptron learning rule. Each clock cycle is one independent
//            sample: the activation of the current sample is registered as
//            the prediction and, while training, drives the weight update.
// Params   : input_units   - number of inputs / weights (>= 1)
// Ports    : clk                      in  1    rising-edge clock
//            rst                      in  1    asynchronous reset, active low
//            values   [input_units]   in  sfp  input sample
//            training                 in  1    1 = apply learning rule
//            learning_rate            in  sfp  learning step (ONE = 1.0)
//            expected                 in  sfp  target label (0 or ONE)
//            prediction               out sfp  registered activation
//            weights  [input_units]   out sfp  current weights
//            bias                     out sfp  current bias
// Revision : 1.0 - initial release
// ============================================================================
module perceptron_introduction
  import fixed_point_pkg::*;
#(
  parameter int input_units = 2
) (
  input  logic clk,
  input  logic rst,
  input  sfp   values [input_units],
  input  logic training,
  input  sfp   learning_rate,
  input  sfp   expected,
  output sfp   prediction,
  output sfp   weights [input_units],
  output sfp   bias
);

  sfp weight_reg [input_units];
  sfp bias_reg;
  sfp prediction_reg;

  sfp sum;
  sfp act;
  sfp err;
  sfp delta;

  perceptron_dot #(
    .input_units (input_units)
  ) u_dot (
    .weights (weight_reg),
    .values  (values),
    .bias    (bias_reg),
    .sum     (sum)
  );

  // Step activation: strictly positive sum fires, so sum == 0 gives 0.
  assign act = (sum > 0) ? ONE : '0;

  // The error uses the combinational activation of the sample on the inputs
  // right now, not the registered prediction (which belongs to the previous
  // sample). A correct prediction gives err = 0, hence delta = 0 and every
  // update term below collapses to zero.
  assign err   = expected - act;
  assign delta = sfp_mul(learning_rate, err);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < input_units; i++) begin
        weight_reg[i] <= '0;
      end
      bias_reg       <= '0;
      prediction_reg <= '0;
    end else begin
      prediction_reg <= act;
      if (training) begin
        for (int i = 0; i < input_units; i++) begin
          weight_reg[i] <= weight_reg[i] + sfp_mul(delta, values[i]);
        end
        bias_reg <= bias_reg + delta;
      end
    end
  end

  generate
    for (genvar i = 0; i < input_units; i++) begin : g_weight_out
      assign weights[i] = weight_reg[i];
    end
  endgenerate

  assign bias       = bias_reg;
  assign prediction = prediction_reg;

endmodule : perceptron_introduction
`default_nettype wire

// File: tb/tb_perceptron_introduction.sv
`default_nettype none
// ============================================================================
// Module   : tb_perceptron_introduction
// Purpose  : Directed self-checking bench for perceptron_introduction with
//            hand-computed expected weights, bias and predictions.
// Revision : 1.0 - initial release
// ============================================================================
module tb_perceptron_introduction;
  import fixed_point_pkg::*;

  logic clk;
  logic rst;
  sfp   values [2];
  logic training;
  sfp   learning_rate;
  sfp   expected;
  sfp   prediction;
  sfp   weights [2];
  sfp   bias;

  int n_compared;
  int n_mismatched;

  // AND truth table, one sample per cycle in this order.
  sfp and_x0 [4];
  sfp and_x1 [4];
  sfp and_y  [4];

  // Hand-traced state at the end of each AND epoch (integer units of ONE).
  int ep_w0 [10];
  int ep_w1 [10];
  int ep_b  [10];

  perceptron_introduction #(
    .input_units (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .values        (values),
    .training      (training),
    .learning_rate (learning_rate),
    .expected      (expected),
    .prediction    (prediction),
    .weights       (weights),
    .bias          (bias)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_value(input string tag, input sfp got, input sfp exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag, input sfp w0, input sfp w1, input sfp b);
    check_value($sformatf("%s.w0", tag), weights[0], w0);
    check_value($sformatf("%s.w1", tag), weights[1], w1);
    check_value($sformatf("%s.bias", tag), bias, b);
  endtask

  // Leaves time at 1 unit after a rising edge, where inputs are changed and
  // outputs are sampled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input sfp v0, input sfp v1, input sfp e);
    values[0] = v0;
    values[1] = v1;
    expected  = e;
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic run_and_epochs(input string tag, input int n_epochs);
    for (int ep = 0; ep < n_epochs; ep++) begin
      for (int s = 0; s < 4; s++) begin
        apply(and_x0[s], and_x1[s], and_y[s]);
        tick();
      end
      check_state($sformatf("%s_ep%0d", tag, ep + 1),
                  int_to_sfp(ep_w0[ep]), int_to_sfp(ep_w1[ep]), int_to_sfp(ep_b[ep]));
    end
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    and_x0 = '{32'sh0, 32'sh0, ONE, ONE};
    and_x1 = '{32'sh0, ONE, 32'sh0, ONE};
    and_y  = '{32'sh0, 32'sh0, 32'sh0, ONE};
    ep_w0  = '{1, 2, 2, 2, 2, 2, 2, 2, 2, 2};
    ep_w1  = '{1, 1, 1, 2, 1, 1, 1, 1, 1, 1};
    ep_b   = '{1, 0, -1, -1, -2, -2, -2, -2, -2, -2};

    // ---------------- reset with arbitrary inputs ----------------
    rst           = 1'b1;
    training      = 1'b1;
    learning_rate = ONE;
    apply(32'sh1234_5678, 32'sh7fff_0000, ONE);
    #2 rst = 1'b0;
    #1;
    check_state("reset_async", 32'sh0, 32'sh0, 32'sh0);
    check_value("reset_async.pred", prediction, 32'sh0);
    tick();
    tick();
    check_state("reset_hold", 32'sh0, 32'sh0, 32'sh0);
    check_value("reset_hold.pred", prediction, 32'sh0);

    // ---------------- single update from zero ----------------
    apply(ONE, ONE, ONE);
    rst = 1'b1;
    tick();
    check_state("single", ONE, ONE, ONE);
    check_value("single.pred", prediction, 32'sh0);
    // Frozen now; sum = 3*ONE > 0 so the next prediction is ONE.
    training = 1'b0;
    tick();
    check_value("single_next.pred", prediction, ONE);
    check_state("single_frozen", ONE, ONE, ONE);

    // ---------------- fractional rate, negative input ----------------
    pulse_reset();
    training      = 1'b1;
    learning_rate = 32'sh0000_8000;             // 0.5
    apply(ONE, -int_to_sfp(2), ONE);
    tick();
    // delta = 0.5; w0 = 0.5*1, w1 = 0.5*(-2) = -1, bias = 0.5
    check_state("frac", 32'sh0000_8000, 32'shFFFF_0000, 32'sh0000_8000);

    // ---------------- AND training, 10 epochs ----------------
    training      = 1'b0;
    learning_rate = ONE;
    pulse_reset();
    training = 1'b1;
    run_and_epochs("and", 10);

    // ---------------- inference ----------------
    training = 1'b0;
    for (int s = 0; s < 4; s++) begin
      apply(and_x0[s], and_x1[s], 32'sh0);
      tick();
      check_value($sformatf("infer%0d.pred", s), prediction, and_y[s]);
    end
    check_state("infer", int_to_sfp(2), ONE, -int_to_sfp(2));

    // ---------------- frozen with mismatching label ----------------
    apply(ONE, ONE, 32'sh0);
    for (int c = 0; c < 10; c++) begin
      tick();
    end
    check_state("frozen", int_to_sfp(2), ONE, -int_to_sfp(2));
    check_value("frozen.pred", prediction, ONE);

    // ---------------- async reset during epoch 3 ----------------
    pulse_reset();
    training = 1'b1;
    run_and_epochs("pre", 2);
    for (int s = 0; s < 2; s++) begin
      apply(and_x0[s], and_x1[s], and_y[s]);
      tick();
    end
    // Mid-epoch-3 state is w=(2,0), b=-1; reset must clear it before the
    // next rising edge.
    check_state("mid3", int_to_sfp(2), 32'sh0, -ONE);
    #2 rst = 1'b0;
    #1;
    check_state("mid_reset", 32'sh0, 32'sh0, 32'sh0);
    check_value("mid_reset.pred", prediction, 32'sh0);
    tick();
    tick();
    rst = 1'b1;
    run_and_epochs("retrain", 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule : tb_perceptron_introduction
`default_nettype wire
